// File: rtl/pwr_pkg.sv
// Shared types and defaults for the PWR domain stop/standby responder.
// The state encoding is fixed because it is visible on the FSM state ports.
package pwr_pkg;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_ISO   = 3'd1,
        S_STOP  = 3'd2,
        S_OFF   = 3'd3,
        S_PWRUP = 3'd4,
        S_DEISO = 3'd5,
        S_WKUP  = 3'd6
    } pwr_dom_state_t;

    localparam int PWR_ISO_DLY_DEF   = 4;
    localparam int PWR_PWRUP_DLY_DEF = 16;

    // A domain is parked once it sits isolated in STOP or powered down in OFF.
    function automatic logic pwr_is_parked(input logic [2:0] st);
        return (pwr_dom_state_t'(st) == S_STOP) || (pwr_dom_state_t'(st) == S_OFF);
    endfunction

endpackage

// File: rtl/pwr_domain_fsm.sv
// Per-domain stop/standby sequencer: isolation, power switch and wake handshake.
// Cross-domain ordering arrives through enter_ok_i / exit_ok_i.
module pwr_domain_fsm
    import pwr_pkg::*;
#(
    parameter bit HAS_OFF   = 1'b1,
    parameter int ISO_DLY   = PWR_ISO_DLY_DEF,
    parameter int PWRUP_DLY = PWR_PWRUP_DLY_DEF,
    parameter int CNT_W     = $clog2(PWRUP_DLY + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       pdds_i,
    input  logic       wkup_evt_i,
    input  logic       enter_ok_i,
    input  logic       exit_ok_i,
    output logic [2:0] state_o,
    output logic [2:0] state_d_o,
    output logic       iso_en_o,
    output logic       sw_on_o,
    output logic       ok_o,
    output logic       wkup_o
);

    localparam logic [CNT_W-1:0] ISO_LAST   = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    pwr_dom_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             iso_en_q, iso_en_d;
    logic             sw_on_q, sw_on_d;
    logic             ok_q, ok_d;
    logic             wkup_q, wkup_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            iso_en_q <= 1'b0;
            sw_on_q  <= 1'b1;
            ok_q     <= 1'b1;
            wkup_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            iso_en_q <= iso_en_d;
            sw_on_q  <= sw_on_d;
            ok_q     <= ok_d;
            wkup_q   <= wkup_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (req_i && enter_ok_i) state_d = S_ISO;
            S_ISO:   if (cnt_q == ISO_LAST) state_d = (HAS_OFF && pdds_i) ? S_OFF : S_STOP;
            S_STOP:  if (pend_q && exit_ok_i) state_d = S_DEISO;
            S_OFF:   if (pend_q && exit_ok_i) state_d = S_PWRUP;
            S_PWRUP: if (cnt_q == PWRUP_LAST) state_d = S_DEISO;
            S_DEISO: if (cnt_q == ISO_LAST) state_d = S_WKUP;
            S_WKUP:  if (!req_i) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);

        // An event coinciding with RUN->ISO is kept so the domain wakes straight back up.
        pend_d = pend_q;
        if (wkup_evt_i && state_q != S_WKUP && state_d != S_RUN) pend_d = 1'b1;
        if (state_d == S_WKUP && state_q != S_WKUP) pend_d = 1'b0;

        iso_en_d = state_d inside {S_ISO, S_STOP, S_OFF, S_PWRUP};
        sw_on_d  = (state_d != S_OFF);
        ok_d     = !(state_d inside {S_OFF, S_PWRUP});
        wkup_d   = (state_d == S_WKUP);
    end

    assign state_o   = state_q;
    assign state_d_o = state_d;
    assign iso_en_o  = iso_en_q;
    assign sw_on_o   = sw_on_q;
    assign ok_o      = ok_q;
    assign wkup_o    = wkup_q;

endmodule

// File: rtl/pwr_domain_stop_ctrl.sv
// RCC stop/standby responder for D1/D2/D3: three domain sequencers plus the
// cross-domain ordering and the regulator low-power enable.
module pwr_domain_stop_ctrl
    import pwr_pkg::*;
#(
    parameter int ISO_DLY   = PWR_ISO_DLY_DEF,
    parameter int PWRUP_DLY = PWR_PWRUP_DLY_DEF,
    parameter int CNT_W     = $clog2(PWRUP_DLY + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rcc_pwr_d1_req,
    input  logic rcc_pwr_d2_req,
    input  logic rcc_pwr_d3_req,
    input  logic d1_pdds,
    input  logic d2_pdds,
    input  logic d1_wkup_evt,
    input  logic d2_wkup_evt,
    input  logic d3_wkup_evt,
    output logic pwr_d1_ok,
    output logic pwr_d2_ok,
    output logic pwr_d1_wkup,
    output logic pwr_d2_wkup,
    output logic pwr_d3_wkup,
    output logic d1_iso_en,
    output logic d2_iso_en,
    output logic d3_iso_en,
    output logic d1_sw_on,
    output logic d2_sw_on,
    output logic vcore_lp_en
);

    logic [2:0] d1_st, d2_st, d3_st, d3_st_d;
    logic [2:0] unused_d1_st_d, unused_d2_st_d;
    logic       unused_d3_ok, unused_d3_sw_on;
    logic       d3_enter_ok, d12_exit_ok, d3_wkup_any;
    logic       vcore_lp_q;

    // D3 only stops under parked D1/D2; D1/D2 only leave once D3 is running again.
    assign d3_enter_ok = pwr_is_parked(d1_st) && pwr_is_parked(d2_st);
    assign d12_exit_ok = (pwr_dom_state_t'(d3_st) == S_RUN);
    assign d3_wkup_any = d3_wkup_evt || d1_wkup_evt || d2_wkup_evt;

    pwr_domain_fsm #(
        .HAS_OFF(1'b1), .ISO_DLY(ISO_DLY), .PWRUP_DLY(PWRUP_DLY), .CNT_W(CNT_W)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .req_i(rcc_pwr_d1_req), .pdds_i(d1_pdds), .wkup_evt_i(d1_wkup_evt),
        .enter_ok_i(1'b1), .exit_ok_i(d12_exit_ok),
        .state_o(d1_st), .state_d_o(unused_d1_st_d),
        .iso_en_o(d1_iso_en), .sw_on_o(d1_sw_on), .ok_o(pwr_d1_ok), .wkup_o(pwr_d1_wkup)
    );

    pwr_domain_fsm #(
        .HAS_OFF(1'b1), .ISO_DLY(ISO_DLY), .PWRUP_DLY(PWRUP_DLY), .CNT_W(CNT_W)
    ) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .req_i(rcc_pwr_d2_req), .pdds_i(d2_pdds), .wkup_evt_i(d2_wkup_evt),
        .enter_ok_i(1'b1), .exit_ok_i(d12_exit_ok),
        .state_o(d2_st), .state_d_o(unused_d2_st_d),
        .iso_en_o(d2_iso_en), .sw_on_o(d2_sw_on), .ok_o(pwr_d2_ok), .wkup_o(pwr_d2_wkup)
    );

    pwr_domain_fsm #(
        .HAS_OFF(1'b0), .ISO_DLY(ISO_DLY), .PWRUP_DLY(PWRUP_DLY), .CNT_W(CNT_W)
    ) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .req_i(rcc_pwr_d3_req), .pdds_i(1'b0), .wkup_evt_i(d3_wkup_any),
        .enter_ok_i(d3_enter_ok), .exit_ok_i(1'b1),
        .state_o(d3_st), .state_d_o(d3_st_d),
        .iso_en_o(d3_iso_en), .sw_on_o(unused_d3_sw_on), .ok_o(unused_d3_ok), .wkup_o(pwr_d3_wkup)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vcore_lp_q <= 1'b0;
        else        vcore_lp_q <= (pwr_dom_state_t'(d3_st_d) == S_STOP);
    end

    assign vcore_lp_en = vcore_lp_q;

endmodule
